pe_conv1d_ctrl: RTL and testbench
=================================

# pe_conv1d_ctrl

Sequencer that turns one processing element (16×16 MAC with 32-bit partial-sum forwarding) into a 1-D convolution engine. It buffers a filter row of S weights and an image row of W activations, then drives the PE one tap per cycle. The PE's registered psum output is fed back as its psum input. Each of the W−S+1 results is returned on a valid/ready stream. It sits between the row loaders and the PE in the array datapath.

## Interface
- MAX_S, 8, maximum filter taps
- MAX_W, 64, maximum image row length
- DW, 16, activation/weight width
- PW, 32, partial-sum width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cfg_valid / cfg_ready  in/out  1  job start handshake
- cfg_s  in  $clog2(MAX_S+1)  filter length S
- cfg_w  in  $clog2(MAX_W+1)  image length W
- wt_valid / wt_ready  in/out  1  weight stream handshake
- wt_data  in  DW  weight, tap 0 first
- img_valid / img_ready  in/out  1  image stream handshake
- img_data  in  DW  activation, pixel 0 first
- pe_image_val, pe_weight_val  out  DW  PE operands
- pe_image_en, pe_weight_en  out  1  PE MAC enables (always equal)
- pe_psum_in  out  PW  PE partial-sum input
- pe_psum_out  in  PW  PE registered partial-sum output
- out_valid / out_ready  out/in  1  result handshake
- out_data  out  PW  convolution result
- out_last  out  1  marks result W−S
- busy  out  1  high in any state but IDLE
- err  out  1  one-cycle pulse on rejected config

## Operation
- States: IDLE → LOAD_W → LOAD_I → MAC → WAIT → OUT → (MAC | IDLE).
- IDLE: cfg_ready=1. A cfg handshake with 1≤S≤MAX_S, 1≤W≤MAX_W and S≤W latches S and W, then goes to LOAD_W. Any other config pulses err, and the state stays IDLE.
- LOAD_W: wt_ready=1. Accept S words into wbuf[0..S−1], then go to LOAD_I.
- LOAD_I: img_ready=1. Accept W words into ibuf[0..W−1], set x=0 and k=0, then go to MAC.
- MAC, one cycle per tap k:
  - pe_image_val = ibuf[x+k]
  - pe_weight_val = wbuf[k]
  - enables = 1
  - pe_psum_in = 0 when k=0, otherwise pe_psum_out
  - After k=S−1, go to WAIT.
- WAIT, one cycle: enables = 0 and pe_psum_in = pe_psum_out. Capture pe_psum_out into out_data and go to OUT.
- OUT: out_valid=1, out_last=(x==W−S). On handshake:
  - if x==W−S, go to IDLE;
  - otherwise x++, k=0, and go to MAC.
- Outside MAC/WAIT, the PE outputs are all 0 and the enables are 0.
- Arithmetic is done in the PE, mod 2^PW, unsigned. The controller does no arithmetic on data.

## Timing
- Reset values: state IDLE, all ready/valid/en/err 0 except cfg_ready=1, all data outputs 0, counters 0. Assertion mid-job aborts immediately; no partial output.
- Load: one word per cycle at full throughput, with no bubbles between LOAD_W and LOAD_I.
- Per result: S MAC cycles, then 1 WAIT cycle, then at least 1 OUT cycle. The first result is out_valid S+1 cycles after the last image handshake.
- out_data, out_last and out_valid are held stable while out_valid && !out_ready.
- New config is accepted only in IDLE. The IDLE after the final OUT handshake accepts cfg in the next cycle.
- Upstream valid while the matching ready is low is ignored; no words are dropped or buffered.

## Configuration
- PE_CTRL_BIAS_EN defined: extra port bias in PW, latched on the cfg handshake. At k=0, pe_psum_in = bias.
- Without the macro: no bias port, and pe_psum_in=0 at k=0.

## Structure
- pe_ctrl_pkg holds:
  - state enum (IDLE, LOAD_W, LOAD_I, MAC, WAIT, OUT)
  - DW and PW localparam defaults
  - config-check function.
- Sub-module pe_ctrl_buf: a parameterized depth×DW register file with one write port and one async read port, instantiated twice (wbuf, ibuf).
- The PE itself is instantiated by the parent, not inside this block.

## Test plan
- S=3, W=5, weights 1,2,3, image 1,2,3,4,5 → out_data 14, 20, 26; out_last only on 26; busy low after.
- Same job, out_ready low 4 cycles at the first result → out_data=14 held stable, no extra MAC cycles, then 20 and 26 follow.
- cfg_s=4, cfg_w=3, then cfg_s=0 → err pulses once per attempt, state stays IDLE, wt_ready never rises.
- S=W=1, weight 7, image 9 → single result 63 with out_last=1, two cycles after the image handshake.
- rst_n low during MAC of the second result → all outputs at reset values; a new job afterwards produces correct results.
- PE_CTRL_BIAS_EN, bias=10, first job's data → 24, 30, 36.

Source files
------------

// File: rtl/pe_ctrl_pkg.sv
// Shared types and helpers for the 1-D convolution PE sequencer.
package pe_ctrl_pkg;

    localparam int DW_DEF = 16;
    localparam int PW_DEF = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        LOAD_I,
        MAC,
        WAIT,
        OUT
    } state_e;

    // A job needs at least one tap, fits both buffers, and yields at least one output.
    function automatic logic cfg_ok(input int s, input int w, input int max_s, input int max_w);
        return (s >= 1) && (s <= max_s) && (w >= 1) && (w <= max_w) && (s <= w);
    endfunction

endpackage

// File: rtl/pe_ctrl_buf.sv
// Depth x DW register file: one synchronous write port, one asynchronous read port.
module pe_ctrl_buf #(
    parameter  int DEPTH = 8,
    parameter  int DW    = 16,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DEPTH-1:0][DW-1:0] mem_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pe_conv1d_ctrl.sv
// Sequences one PE through a 1-D convolution: load S weights and W pixels, then S taps per result.
// Optional macro PE_CTRL_BIAS_EN adds a bias_i port that seeds the psum at tap 0.
module pe_conv1d_ctrl
    import pe_ctrl_pkg::*;
#(
    parameter  int MAX_S = 8,
    parameter  int MAX_W = 64,
    parameter  int DW    = DW_DEF,
    parameter  int PW    = PW_DEF,
    localparam int SW    = $clog2(MAX_S + 1),
    localparam int WW    = $clog2(MAX_W + 1),
    localparam int WAW   = (MAX_S > 1) ? $clog2(MAX_S) : 1,
    localparam int IAW   = (MAX_W > 1) ? $clog2(MAX_W) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_valid_i,
    output logic          cfg_ready_o,
    input  logic [SW-1:0] cfg_s_i,
    input  logic [WW-1:0] cfg_w_i,
`ifdef PE_CTRL_BIAS_EN
    input  logic [PW-1:0] bias_i,
`endif
    input  logic          wt_valid_i,
    output logic          wt_ready_o,
    input  logic [DW-1:0] wt_data_i,
    input  logic          img_valid_i,
    output logic          img_ready_o,
    input  logic [DW-1:0] img_data_i,
    output logic [DW-1:0] pe_image_val_o,
    output logic [DW-1:0] pe_weight_val_o,
    output logic          pe_image_en_o,
    output logic          pe_weight_en_o,
    output logic [PW-1:0] pe_psum_in_o,
    input  logic [PW-1:0] pe_psum_out_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [PW-1:0] out_data_o,
    output logic          out_last_o,
    output logic          busy_o,
    output logic          err_o
);

    state_e        state_q, state_d;
    logic [SW-1:0] s_q, s_d, k_q, k_d;
    logic [WW-1:0] w_q, w_d, cnt_q, cnt_d, x_q, x_d;
    logic [PW-1:0] out_data_q, out_data_d;
    logic          err_q, err_d;

    logic [WW-1:0]  s_ext, x_last_pos;
    logic           x_last, cfg_good;
    logic [IAW-1:0] img_raddr;
    logic [DW-1:0]  wbuf_rd, ibuf_rd;
    logic [PW-1:0]  psum_seed;

    assign s_ext      = WW'(s_q);
    assign x_last_pos = w_q - s_ext;
    assign x_last     = (x_q == x_last_pos);
    assign cfg_good   = cfg_ok(int'(cfg_s_i), int'(cfg_w_i), MAX_S, MAX_W);
    assign img_raddr  = x_q[IAW-1:0] + IAW'(k_q);

`ifdef PE_CTRL_BIAS_EN
    logic [PW-1:0] bias_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bias_q <= '0;
        end else if (state_q == IDLE && cfg_valid_i && cfg_good) begin
            bias_q <= bias_i;
        end
    end

    assign psum_seed = bias_q;
`else
    assign psum_seed = '0;
`endif

    pe_ctrl_buf #(.DEPTH(MAX_S), .DW(DW)) u_wbuf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (state_q == LOAD_W && wt_valid_i),
        .waddr_i (cnt_q[WAW-1:0]),
        .wdata_i (wt_data_i),
        .raddr_i (k_q[WAW-1:0]),
        .rdata_o (wbuf_rd)
    );

    pe_ctrl_buf #(.DEPTH(MAX_W), .DW(DW)) u_ibuf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (state_q == LOAD_I && img_valid_i),
        .waddr_i (cnt_q[IAW-1:0]),
        .wdata_i (img_data_i),
        .raddr_i (img_raddr),
        .rdata_o (ibuf_rd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            s_q        <= '0;
            w_q        <= '0;
            cnt_q      <= '0;
            x_q        <= '0;
            k_q        <= '0;
            out_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            w_q        <= w_d;
            cnt_q      <= cnt_d;
            x_q        <= x_d;
            k_q        <= k_d;
            out_data_q <= out_data_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        w_d        = w_q;
        cnt_d      = cnt_q;
        x_d        = x_q;
        k_d        = k_q;
        out_data_d = out_data_q;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_valid_i) begin
                    if (cfg_good) begin
                        s_d     = cfg_s_i;
                        w_d     = cfg_w_i;
                        cnt_d   = '0;
                        state_d = LOAD_W;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD_W: begin
                if (wt_valid_i) begin
                    if (cnt_q == s_ext - WW'(1)) begin
                        cnt_d   = '0;
                        state_d = LOAD_I;
                    end else begin
                        cnt_d = cnt_q + WW'(1);
                    end
                end
            end
            LOAD_I: begin
                if (img_valid_i) begin
                    if (cnt_q == w_q - WW'(1)) begin
                        cnt_d   = '0;
                        x_d     = '0;
                        k_d     = '0;
                        state_d = MAC;
                    end else begin
                        cnt_d = cnt_q + WW'(1);
                    end
                end
            end
            MAC: begin
                if (k_q == s_q - SW'(1)) begin
                    state_d = WAIT;
                end else begin
                    k_d = k_q + SW'(1);
                end
            end
            WAIT: begin
                out_data_d = pe_psum_out_i;
                state_d    = OUT;
            end
            OUT: begin
                if (out_ready_i) begin
                    if (x_last) begin
                        state_d = IDLE;
                    end else begin
                        x_d     = x_q + WW'(1);
                        k_d     = '0;
                        state_d = MAC;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // PE operands are driven only while a tap or the drain cycle is in flight.
    always_comb begin
        pe_image_val_o  = '0;
        pe_weight_val_o = '0;
        pe_image_en_o   = 1'b0;
        pe_weight_en_o  = 1'b0;
        pe_psum_in_o    = '0;
        case (state_q)
            MAC: begin
                pe_image_val_o  = ibuf_rd;
                pe_weight_val_o = wbuf_rd;
                pe_image_en_o   = 1'b1;
                pe_weight_en_o  = 1'b1;
                pe_psum_in_o    = (k_q == '0) ? psum_seed : pe_psum_out_i;
            end
            WAIT:    pe_psum_in_o = pe_psum_out_i;
            default: ;
        endcase
    end

    assign cfg_ready_o = (state_q == IDLE);
    assign wt_ready_o  = (state_q == LOAD_W);
    assign img_ready_o = (state_q == LOAD_I);
    assign out_valid_o = (state_q == OUT);
    assign out_last_o  = (state_q == OUT) && x_last;
    assign out_data_o  = out_data_q;
    assign busy_o      = (state_q != IDLE);
    assign err_o       = err_q;

endmodule

// File: tb/tb_pe_conv1d_ctrl.sv
// Directed bench for pe_conv1d_ctrl with a behavioural PE closing the psum loop.
module tb_pe_conv1d_ctrl;

`ifdef PE_CTRL_BIAS_EN
    localparam logic [31:0] BIAS = 32'd10;
`else
    localparam logic [31:0] BIAS = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_valid = 1'b0, cfg_ready;
    logic [3:0]  cfg_s = '0;
    logic [6:0]  cfg_w = '0;
    logic [31:0] bias = BIAS;
    logic        wt_valid = 1'b0, wt_ready;
    logic [15:0] wt_data = '0;
    logic        img_valid = 1'b0, img_ready;
    logic [15:0] img_data = '0;
    logic [15:0] pe_image_val, pe_weight_val;
    logic        pe_image_en, pe_weight_en;
    logic [31:0] pe_psum_in, pe_psum_out;
    logic        out_valid, out_ready = 1'b0, out_last, busy, err;
    logic [31:0] out_data;

    int n_asserts = 0;
    int n_fails   = 0;

    always #5 clk = ~clk;

    pe_conv1d_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_valid_i     (cfg_valid),
        .cfg_ready_o     (cfg_ready),
        .cfg_s_i         (cfg_s),
        .cfg_w_i         (cfg_w),
`ifdef PE_CTRL_BIAS_EN
        .bias_i          (bias),
`endif
        .wt_valid_i      (wt_valid),
        .wt_ready_o      (wt_ready),
        .wt_data_i       (wt_data),
        .img_valid_i     (img_valid),
        .img_ready_o     (img_ready),
        .img_data_i      (img_data),
        .pe_image_val_o  (pe_image_val),
        .pe_weight_val_o (pe_weight_val),
        .pe_image_en_o   (pe_image_en),
        .pe_weight_en_o  (pe_weight_en),
        .pe_psum_in_o    (pe_psum_in),
        .pe_psum_out_i   (pe_psum_out),
        .out_valid_o     (out_valid),
        .out_ready_i     (out_ready),
        .out_data_o      (out_data),
        .out_last_o      (out_last),
        .busy_o          (busy),
        .err_o           (err)
    );

    // Behavioural PE: registered psum = psum_in + (en ? a*b : 0), unsigned mod 2^32.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pe_psum_out <= '0;
        else        pe_psum_out <= pe_psum_in +
                                   (pe_image_en ? 32'(pe_image_val) * 32'(pe_weight_val) : 32'd0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cfg(input int s, input int w);
        cfg_valid = 1'b1;
        cfg_s     = 4'(s);
        cfg_w     = 7'(w);
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic push_wt(input int d);
        int g = 0;
        wt_valid = 1'b1;
        wt_data  = 16'(d);
        while (!wt_ready && g < 20) begin step(); g++; end
        chk("wt_ready", wt_ready, 1);
        step();
        wt_valid = 1'b0;
    endtask

    task automatic push_img(input int d);
        int g = 0;
        img_valid = 1'b1;
        img_data  = 16'(d);
        while (!img_ready && g < 20) begin step(); g++; end
        chk("img_ready", img_ready, 1);
        step();
        img_valid = 1'b0;
    endtask

    // Standard job: S=3 W=5, weights 1,2,3, image 1..5.
    task automatic load_std();
        send_cfg(3, 5);
        for (int i = 1; i <= 3; i++) push_wt(i);
        for (int i = 1; i <= 5; i++) push_img(i);
    endtask

    task automatic get_result(input int s, input logic [31:0] exp, input logic last, input int stall);
        int n  = 0;
        int en = 0;
        while (!out_valid && n < 64) begin
            en += int'(pe_image_en);
            step();
            n++;
        end
        chk("latency", n, s + 1);
        chk("mac_cycles", en, s);
        for (int i = 0; i < stall; i++) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, exp);
            chk("stall_en", pe_image_en, 0);
            step();
        end
        chk("out_data", out_data, exp);
        chk("out_last", out_last, last);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_wt_ready", wt_ready, 0);
        chk("rst_img_ready", img_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_en", pe_image_en, 0);
        chk("rst_psum_in", pe_psum_in, 0);
        chk("rst_out_data", out_data, 0);
        step();
        rst_n = 1'b1;
        step();

        // Basic job.
        load_std();
        get_result(3, 32'd14 + BIAS, 1'b0, 0);
        get_result(3, 32'd20 + BIAS, 1'b0, 0);
        get_result(3, 32'd26 + BIAS, 1'b1, 0);
        chk("busy_after", busy, 0);
        chk("cfg_ready_after", cfg_ready, 1);

        // Backpressure on first result.
        load_std();
        get_result(3, 32'd14 + BIAS, 1'b0, 4);
        get_result(3, 32'd20 + BIAS, 1'b0, 0);
        get_result(3, 32'd26 + BIAS, 1'b1, 0);
        chk("busy_after2", busy, 0);

        // Rejected configs.
        send_cfg(4, 3);
        chk("err_s_gt_w", err, 1);
        chk("err_busy", busy, 0);
        chk("err_wt_ready", wt_ready, 0);
        step();
        chk("err_clear", err, 0);
        send_cfg(0, 5);
        chk("err_s_zero", err, 1);
        chk("err_wt_ready2", wt_ready, 0);
        step();
        chk("err_clear2", err, 0);
        chk("err_cfg_ready", cfg_ready, 1);

        // Single tap, single pixel.
        send_cfg(1, 1);
        push_wt(7);
        push_img(9);
        get_result(1, 32'd63 + BIAS, 1'b1, 0);
        chk("busy_after3", busy, 0);

        // Abort during second result's MAC.
        load_std();
        get_result(3, 32'd14 + BIAS, 1'b0, 0);
        step();
        chk("mid_mac_en", pe_image_en, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_en", pe_image_en, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_psum_in", pe_psum_in, 0);
        chk("abort_out_data", out_data, 0);
        chk("abort_cfg_ready", cfg_ready, 1);
        step();
        rst_n = 1'b1;
        step();
        load_std();
        get_result(3, 32'd14 + BIAS, 1'b0, 0);
        get_result(3, 32'd20 + BIAS, 1'b0, 0);
        get_result(3, 32'd26 + BIAS, 1'b1, 0);
        chk("busy_after4", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
